// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, state encoding and constants for the 32-bit divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_addsub_33.sv
// rtl/div_addsub_33.sv - 33-bit adder/subtractor shared by the iteration and fix-up steps.
module div_addsub_33
  import div_pkg::*;
(
  input  logic [DIV_W:0] a,
  input  logic [DIV_W:0] b,
  input  logic           op,
  output logic [DIV_W:0] sum,
  output logic           sign
);

  // op=1 subtracts, op=0 adds
  assign sum  = op ? (a - b) : (a + b);
  assign sign = sum[DIV_W];

endmodule

// File: rtl/nonrestoring_div_32.sv
// rtl/nonrestoring_div_32.sv - 32-bit non-restoring divider, constant 34-edge latency.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module nonrestoring_div_32
  import div_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIV_W-1:0]   dividend,
  input  logic [DIV_W-1:0]   divisor,
  output logic [DIV_W-1:0]   quotient,
  output logic [DIV_W-1:0]   remainder,
  output logic [2*DIV_W-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  state_t           state;
  state_t           state_next;
  logic [DIV_W:0]   part_rem;
  logic [DIV_W-1:0] quo_work;
  logic [DIV_W-1:0] div_reg;
  logic [5:0]       iter;
  logic             zero_pend;
  logic             divisor_zero;

  logic [DIV_W:0]   add_a;
  logic [DIV_W:0]   add_b;
  logic [DIV_W:0]   add_sum;
  logic             add_op;
  logic             add_sign;

  logic [DIV_W-1:0] dividend_mag;
  logic [DIV_W-1:0] divisor_mag;
  logic [DIV_W-1:0] rem_mag;
  logic [DIV_W-1:0] quo_fix;
  logic [DIV_W-1:0] rem_fix;

  assign divisor_zero = (divisor == '0);

  // FIX reuses the adder to restore a negative partial remainder
  assign rem_mag = part_rem[DIV_W] ? add_sum[DIV_W-1:0] : part_rem[DIV_W-1:0];

`ifdef DIV_SIGNED_EN
  logic neg_quo;
  logic neg_rem;

  assign dividend_mag = dividend[DIV_W-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[DIV_W-1]  ? -divisor  : divisor;
  assign quo_fix      = neg_quo ? -quo_work : quo_work;
  assign rem_fix      = neg_rem ? -rem_mag  : rem_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_quo <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
      neg_rem <= dividend[DIV_W-1];
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign quo_fix      = quo_work;
  assign rem_fix      = rem_mag;
`endif

  always_comb begin
    add_b = {1'b0, div_reg};
    if (state == FIX) begin
      add_a  = part_rem;
      add_op = 1'b0;
    end else begin
      add_a  = {part_rem[DIV_W-1:0], quo_work[DIV_W-1]};
      add_op = ~part_rem[DIV_W];
    end
  end

  div_addsub_33 u_addsub (
    .a    (add_a),
    .b    (add_b),
    .op   (add_op),
    .sum  (add_sum),
    .sign (add_sign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Divide-by-zero skips RUN but still passes through FIX so done lands on edge 2
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = divisor_zero ? FIX : RUN;
      RUN:  if (iter == LAST_ITER) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      part_rem    <= '0;
      quo_work    <= '0;
      div_reg     <= '0;
      iter        <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            part_rem  <= '0;
            div_reg   <= divisor_mag;
            iter      <= '0;
            zero_pend <= divisor_zero;
            quo_work  <= divisor_zero ? dividend : dividend_mag;
          end
        end
        RUN: begin
          part_rem <= add_sum;
          quo_work <= {quo_work[DIV_W-2:0], ~add_sign};
          iter     <= iter + 6'd1;
        end
        FIX: begin
          if (zero_pend) begin
            quotient    <= DIV_ZERO_Q;
            remainder   <= quo_work;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= quo_fix;
            remainder   <= rem_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == RUN) || (state == FIX);
  assign done   = (state == DONE);
  assign result = {remainder, quotient};

endmodule

// File: tb/tb_nonrestoring_div_32.sv
// tb/tb_nonrestoring_div_32.sv - directed vector bench for nonrestoring_div_32.
module tb_nonrestoring_div_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [63:0] result;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  nonrestoring_div_32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one division and wait (bounded) for done; lat counts edges from the accepting edge
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 1;
    busy_ok = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int lat;
    logic busy_ok;
    int dones;
    logic [31:0] q_hold;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34});
    vecs.push_back('{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 2});
`else
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        1'b0, 34});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34});
    vecs.push_back('{32'h12345678, 32'h10,       32'h01234567, 32'd8,        1'b0, 34});
`endif
    vecs.push_back('{32'd100,     32'd7,    32'd14,        32'd2, 1'b0, 34});
    vecs.push_back('{32'd5,       32'd0,    32'hFFFFFFFF,  32'd5, 1'b1, 2});
    vecs.push_back('{32'd10,      32'd3,    32'd3,         32'd1, 1'b0, 34});
    vecs.push_back('{32'd0,       32'd5,    32'd0,         32'd0, 1'b0, 34});
    vecs.push_back('{32'd7,       32'd100,  32'd0,         32'd7, 1'b0, 34});
    vecs.push_back('{32'd1000000, 32'd1000, 32'd1000,      32'd0, 1'b0, 34});

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", {32'd0, quotient}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_div(vecs[i].a, vecs[i].b, lat, busy_ok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), {63'd0, busy_ok}, 64'd1);
      chk($sformatf("v%0d_result", i), result, {vecs[i].r, vecs[i].q});
      chk($sformatf("v%0d_quotient", i), {32'd0, quotient}, {32'd0, vecs[i].q});
      chk($sformatf("v%0d_remainder", i), {32'd0, remainder}, {32'd0, vecs[i].r});
      chk($sformatf("v%0d_dz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dz});
      chk($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    // Outputs hold after completion
    q_hold = quotient;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_quotient", {32'd0, quotient}, 64'd1000);
    chk("hold_remainder", {32'd0, remainder}, 64'd0);
    chk("hold_idle_q", {32'd0, q_hold}, 64'd1000);

    // Second start at edge 5 is ignored
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("busy_start_latency", 64'(lat), 64'd34);
    chk("busy_start_result", result, {32'd2, 32'd14});
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    chk("busy_start_no_second_done", 64'(dones), 64'd0);

    // Reset at edge 10 aborts the operation
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
    chk("midrun_rst_result", result, 64'd0);
    chk("midrun_rst_flags", {62'd0, done, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_idle", {62'd0, busy, done}, 64'd0);
    do_div(32'd100, 32'd7, lat, busy_ok);
    chk("after_rst_latency", 64'(lat), 64'd34);
    chk("after_rst_result", result, {32'd2, 32'd14});
    chk("after_rst_dz", {63'd0, div_by_zero}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
